shift_mult_sequencer: RTL and testbench

Sequential shift-add unsigned multiplier with its control FSM. It takes one operand pair per start pulse and performs one add/shift step per clock over WIDTH cycles. It then presents a registered 2*WIDTH-bit product with a one-cycle done pulse. It is the clocked, controlled replacement for the combinational shift-add multiplier and is the arithmetic unit driven by higher-level sequencing logic.

---
 rtl/shift_mult_pkg.sv | 22 ++
 rtl/shift_add_datapath.sv | 49 ++++
 rtl/shift_mult_sequencer.sv | 105 ++++++++++
 tb/tb_shift_mult_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/shift_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
`timescale 1ns/1ps

package shift_mult_pkg;

    // Controller states; all four 2-bit codes are used.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operand width used when the instantiating design does not override it.
    localparam int DEFAULT_WIDTH = 4;

    // Step-counter width: it must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-add datapath: multiplicand M, multiplier/low-product Q, and
// accumulator A with a carry bit. It is driven by load/step strobes.
`timescale 1ns/1ps

module shift_add_datapath
    import shift_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]   i_y,
    output logic [2*WIDTH-1:0] o_product
);

    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   w_sum;

    // Conditional add of the multiplicand. The carry is kept in the top bit of A.
    always_comb begin
        w_sum = r_q[0] ? (r_a + {1'b0, r_m}) : r_a;
    end

    // Operand capture on load. On each step, {sum,Q} shifts right by one with a 0 entering the top.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here is a plain flop, so all are cleared by the async reset; state uses <= so all flops update together.
        if (rst) begin
            r_a <= '0;
            r_q <= '0;
            r_m <= '0;
        end else if (i_load) begin
            r_m <= i_x;
            r_q <= i_y;
            r_a <= '0;
        end else if (i_step) begin
            r_a <= {1'b0, w_sum[WIDTH:1]};
            r_q <= {w_sum[0], r_q[WIDTH-1:1]};
        end
    end

    // The carry bit is always 0 after the last shift, so it is dropped from the product.
    assign o_product = {r_a[WIDTH-1:0], r_q};

endmodule

// File: rtl/shift_mult_sequencer.sv
// Sequential unsigned multiplier: the FSM accepts one operand pair per start,
// runs WIDTH add/shift steps, then registers the product with a one-cycle done.
`timescale 1ns/1ps

module shift_mult_sequencer
    import shift_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load;
    logic               w_step;
    logic [2*WIDTH-1:0] w_product;
    logic               r_done;
    logic [2*WIDTH-1:0] r_p;

    shift_add_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_x       (x),
        .i_y       (y),
        .o_product (w_product)
    );

    // Next-state logic and datapath strobes. Start is only honoured in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: w_state_nxt = CALC;
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Step counter: loaded with WIDTH on accept, decremented once per CALC step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= CNT_W'(WIDTH);
        end else if (w_step) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Product register and done pulse. Both are updated together when leaving DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_p <= w_product;
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign p    = r_p;

endmodule

// File: tb/tb_shift_mult_sequencer.sv
// Self-checking bench for shift_mult_sequencer. It uses directed and random
// operand pairs on a WIDTH=4 and a WIDTH=8 instance. Expected values come from
// plain multiplication and the WIDTH+2 cycle latency rule.
`timescale 1ns/1ps

module tb_shift_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start8;
    logic [3:0]  x4, y4;
    logic [7:0]  x8, y8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_mult_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
        .busy(busy4), .done(done4), .p(p4)
    );

    shift_mult_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .p(p8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock. Inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One multiply on the chosen instance. The reference model is a*b, done after WIDTH+2 edges.
    task automatic run_op(input bit w8, input int a, input int b, input string tag);
        int          lat  = w8 ? 10 : 6;
        int          n    = 0;
        bit          seen = 1'b0;
        logic [31:0] exp  = 32'(a * b);
        if (w8) begin
            x8 = 8'(a); y8 = 8'(b); start8 = 1'b1;
        end else begin
            x4 = 4'(a); y4 = 4'(b); start4 = 1'b1;
        end
        step();
        start4 = 1'b0;
        start8 = 1'b0;
        while (n < 30 && !seen) begin
            step();
            n++;
            seen = w8 ? done8 : done4;
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " product"}, w8 ? 32'(p8) : 32'(p4), exp);
        check({tag, " busy at done"}, 32'(w8 ? busy8 : busy4), 32'd0);
        step();
        check({tag, " done one cycle"}, 32'(w8 ? done8 : done4), 32'd0);
    endtask

    initial begin
        int n_done;
        int last;
        int a;
        int b;

        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        x4 = '0; y4 = '0; x8 = '0; y8 = '0;
        step();
        step();
        check("reset p4", 32'(p4), 32'd0);
        check("reset busy4", 32'(busy4), 32'd0);
        check("reset done4", 32'(done4), 32'd0);
        check("reset p8", 32'(p8), 32'd0);
        check("reset busy8", 32'(busy8), 32'd0);
        rst = 1'b0;
        step();

        run_op(1'b0, 13, 11, "13x11");
        run_op(1'b0, 15, 15, "15x15");
        run_op(1'b0, 0, 9, "0x9");
        run_op(1'b0, 9, 0, "9x0");

        // A second start during CALC must be dropped.
        x4 = 4'd7; y4 = 4'd5; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        check("busy mid calc", 32'(busy4), 32'd1);
        x4 = 4'd2; y4 = 4'd3; start4 = 1'b1;
        step();
        start4 = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (done4) n_done++;
        end
        check("drop single done", 32'(n_done), 32'd1);
        check("drop product", 32'(p4), 32'd35);
        check("drop busy idle", 32'(busy4), 32'd0);
        run_op(1'b0, 2, 3, "2x3 after drop");

        // Asynchronous reset in the middle of CALC.
        x4 = 4'd12; y4 = 4'd12; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("async rst p", 32'(p4), 32'd0);
        check("async rst busy", 32'(busy4), 32'd0);
        check("async rst done", 32'(done4), 32'd0);
        step();
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done4) n_done++;
        end
        check("no done after abort", 32'(n_done), 32'd0);
        run_op(1'b0, 12, 12, "12x12 after rst");

        // start held high: a new multiply begins each time IDLE is reached.
        x4 = 4'd5; y4 = 4'd6; start4 = 1'b1;
        n_done = 0;
        last = -1;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (done4) begin
                n_done++;
                check("held product", 32'(p4), 32'd30);
                if (last >= 0) check("held spacing", 32'(i - last), 32'd7);
                else           check("held first done", 32'(i), 32'd7);
                last = i;
            end
        end
        start4 = 1'b0;
        check("held done count", 32'(n_done), 32'd3);
        for (int i = 0; i < 10; i++) step();

        // Random operands on the narrow instance.
        for (int i = 0; i < 12; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            run_op(1'b0, a, b, $sformatf("rnd4 %0dx%0d", a, b));
        end

        // Wide instance, including the largest product.
        run_op(1'b1, 255, 255, "255x255");
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_op(1'b1, a, b, $sformatf("rnd8 %0dx%0d", a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
